shift_add_mult: RTL and testbench

- Iterative unsigned shift-and-add multiplier, one partial-product add per clock.
- Sits directly upstream of the N-bit ripple-carry adder datapath and drives its A/B/Cin operands every cycle.
- Consumes the adder's Sum/Cout to build a 2N-bit product.
- Replaces a flat array multiplier where area matters more than latency.

---
 rtl/mult_pkg.sv | 7 +
 rtl/mult_add_stage.sv | 26 ++
 rtl/shift_add_mult.sv | 103 ++++++++++
 tb/tb_shift_add_mult.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and default width for the shift-add multiplier
package mult_pkg;
  localparam int         MULT_N = 6;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/mult_add_stage.sv
// rtl/mult_add_stage.sv - N-bit ripple-carry add of ACC and the gated multiplicand
// Returns {Cout,Sum}; the carry-out becomes the next ACC MSB in the multiplier.
module mult_add_stage
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N:0]   o_sum
);

  logic [N:0]   w_c;
  logic [N-1:0] w_s;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign w_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_sum = {w_c[N], w_s};

endmodule

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - iterative unsigned shift-and-add multiplier, one add per clock
// Optional MULT_ZERO_SKIP_EN: zero operands bypass RUN and finish one cycle after accept.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int N  = MULT_N,
  parameter int CW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  logic [1:0]     r_state;
  logic [1:0]     w_next;
  logic [N-1:0]   r_m;
  logic [N-1:0]   r_acc;
  logic [N-1:0]   r_q;
  logic [CW-1:0]  r_count;
  logic [2*N-1:0] r_product;
  logic [N-1:0]   w_addend;
  logic [N:0]     w_add;
  logic [2*N-1:0] w_shifted;
  logic           w_last;
  logic           w_zero;

  assign w_addend  = r_q[0] ? r_m : '0;
  // {Cout,Sum,Q} >> 1 keeps Cout as the new ACC MSB and drops Q[0].
  assign w_shifted = {w_add, r_q[N-1:1]};
  assign w_last    = (r_count == CW'(N - 1));

`ifdef MULT_ZERO_SKIP_EN
  assign w_zero = (a == '0) || (b == '0);
`else
  assign w_zero = 1'b0;
`endif

  mult_add_stage #(.N(N)) u_add (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .i_cin (1'b0),
    .o_sum (w_add)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_zero ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_m     <= a;
          r_q     <= b;
          r_acc   <= '0;
          r_count <= '0;
          if (w_zero) r_product <= '0;
        end
        S_RUN: begin
          {r_acc, r_q} <= w_shifted;
          r_count      <= r_count + CW'(1);
          if (w_last) r_product <= w_shifted;
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - scoreboard bench for shift_add_mult against an arithmetic reference
module tb_shift_add_mult;
  localparam int N = 6;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] product;

  shift_add_mult #(.N(N), .CW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] prod;
    int           due;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           free_edge = 0;
  int           busy_until = -10;
  int           lat;
  logic [W-1:0] held = '0;
  logic         prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles from accept edge to the sampled done pulse.
  function automatic int latency(input logic [N-1:0] x, input logic [N-1:0] y);
`ifdef MULT_ZERO_SKIP_EN
    if (x == '0 || y == '0) return 0;
`endif
    return N;
  endfunction

  // Reference model: an accept happens whenever start is seen once the previous job has cleared.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      busy_until = -10;
      free_edge  = cyc + 1;
    end else if (start && cyc >= free_edge) begin
      lat = latency(a, b);
      sb.push_back('{prod: W'(a) * W'(b), due: cyc + lat});
      busy_until = cyc + lat;
      free_edge  = cyc + lat + 2;
    end
  end

  // Monitor: compares every cycle, pops the scoreboard on each done pulse.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb.delete();
      held      = '0;
      prev_done = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(cyc <= busy_until));
      if (done) begin
        chk("done_not_consecutive", 32'(prev_done), 32'd0);
        chk("done_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.due));
          chk("product", 32'(product), 32'(e.prod));
          held = e.prod;
        end
      end else begin
        chk("product_held", 32'(product), 32'(held));
        if (sb.size() != 0 && cyc > sb[0].due) begin
          chk("done_missed", 32'(cyc), 32'(sb[0].due));
          void'(sb.pop_front());
        end
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || cyc + 1 < free_edge) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 300), 32'd1);
  endtask

  task automatic pulse(input logic [N-1:0] x, input logic [N-1:0] y);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    pulse(6'd5, 6'd7);   wait_idle();
    pulse(6'd63, 6'd63); wait_idle();
    pulse(6'd0, 6'd42);  wait_idle();
    pulse(6'd42, 6'd0);  wait_idle();

    // A start raised mid-RUN must be dropped.
    pulse(6'd3, 6'd4);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 6'd9; b = 6'd9;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset between edges aborts the job.
    pulse(6'd10, 6'd10);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulse(6'd2, 6'd3);
    wait_idle();

    @(negedge clk);
    start = 1'b1; a = 6'd1; b = 6'd1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_idle();

    repeat (400) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
    end
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
